knap_search_ctrl: RTL and testbench
===================================

Name: knap_search_ctrl

Overview:
- Sequential driver that sits directly upstream of the combinational knapsack validity checker.
- Enumerates every item-selection vector, presents each to the checker one per cycle, and samples the checker's `valid` in the same cycle.
- Reports the number of valid selections and the first valid selection found, with a start/done handshake to the host.

Parameters:
- N_ITEMS, 25, number of items; width of the selection vector; equals checker input count.
- CNT_W, N_ITEMS+1, width of the solution counter; holds 2^N_ITEMS without overflow.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE or DONE.
- abort  in  1  cancels a running search; returns to IDLE.
- stop_first  in  1  sampled with start; 1 = finish at the first valid selection.
- cand  out  N_ITEMS  registered selection vector driven to the checker; bit 0 = item A.
- chk_valid  in  1  checker result for the current `cand`, combinational from `cand`.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start or abort.
- found  out  1  at least one valid selection seen in the current or last search.
- first_sol  out  N_ITEMS  first `cand` for which chk_valid=1; 0 if none.
- sol_count  out  CNT_W  number of valid selections counted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cand=0, busy=0, done=0, found=0, first_sol=0, sol_count=0; the stop_first latch clears to 0.
- States:
  - IDLE: waits for start.
  - RUN: enumerating.
  - DONE: result held.
- IDLE/DONE + start=1 (abort=0):
  - Next state RUN; cand=0; sol_count=0; found=0; first_sol=0; latch stop_first.
  - busy=1 and done=0 from the next cycle.
- RUN, each cycle, evaluates the current `cand` using chk_valid sampled at the clock edge:
  - If chk_valid=1: sol_count+=1.
  - If chk_valid=1 and found=0: first_sol<=cand and found<=1.
  - If chk_valid=1 and the latched stop_first=1: go to DONE. `cand` holds the winning vector; sol_count=1.
  - Else if cand == 2^N_ITEMS-1: go to DONE. The last vector is evaluated; `cand` holds the all-ones vector and does not wrap to 0.
  - Else: cand<=cand+1.
- Latency: a full search takes exactly 2^N_ITEMS cycles in RUN, then done=1 on the following cycle. For stop_first, done rises the cycle after the first valid `cand` is presented.
- DONE: busy=0, done=1. All results are stable until the next start; `cand` is frozen.
- Abort:
  - abort=1 in RUN goes to IDLE next cycle: busy=0, done=0.
  - Results keep their partial values; cand=0.
  - abort in IDLE or DONE goes to IDLE and clears done; results are kept.
- Simultaneous events:
  - abort and start in the same cycle: abort wins.
  - start during RUN is ignored.
  - A stop_first change after start has no effect until the next start.
- sol_count never saturates: CNT_W covers 2^N_ITEMS.
- chk_valid is combinational from `cand`. The block adds no register between `cand` and the evaluation of chk_valid; the single-cycle path through the checker must meet timing.
- Reset mid-search aborts immediately to the reset values.

Test Plan:
- N_ITEMS=4, bench model valid = (cand==4'b0101 || cand==4'b1100); start, stop_first=0 -> busy for exactly 16 cycles; done=1; sol_count=2; first_sol=4'b0101; found=1; cand=4'b1111.
- Same model with stop_first=1 -> done on the 7th cycle after start (cand values 0..5 evaluated); first_sol=5; sol_count=1; cand=5.
- Model valid = 0 always -> after 16 RUN cycles: done=1, found=0, sol_count=0, first_sol=0.
- Model valid = 1 always, N_ITEMS=4 -> sol_count=16 with no overflow; first_sol=0.
- Abort at RUN cycle 3, then start+abort together, then start alone -> IDLE with done=0; second request ignored; third request runs fully with counters cleared.
- Assert rst_n=0 asynchronously mid-RUN -> all outputs 0 immediately; a start after release runs a clean search.
- N_ITEMS=25 with a checker instance wired to `cand` and valid injected only at cand=0x0000123 -> first_sol=0x0000123 with stop_first=1.

Source files
------------

// File: rtl/knap_search_ctrl.sv
// knap_search_ctrl: exhaustive search driver for the combinational knapsack
// validity checker. It walks every selection vector on `cand`, one per cycle,
// samples the checker's verdict in the same cycle, and reports how many
// selections are valid and which one was valid first.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   start       - begin a search (honoured in IDLE or DONE)
//   abort       - cancel; always returns to IDLE, wins over start
//   stop_first  - sampled with start; stop at the first valid selection
//   cand        - registered selection vector to the checker (bit 0 = item A)
//   chk_valid   - checker verdict for the current cand
//   busy, done  - search running / result held
//   found, first_sol, sol_count - search results
module knap_search_ctrl #(
    parameter int unsigned N_ITEMS = 25,
    parameter int unsigned CNT_W   = N_ITEMS + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               stop_first,
    output logic [N_ITEMS-1:0] cand,
    input  logic               chk_valid,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] first_sol,
    output logic [CNT_W-1:0]   sol_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N_ITEMS-1:0] CAND_LAST = '1;

    state_t             state, state_nxt;
    logic [N_ITEMS-1:0] cand_nxt, first_sol_nxt;
    logic [CNT_W-1:0]   sol_count_nxt;
    logic               found_nxt, busy_nxt, done_nxt;
    logic               stop_lat, stop_lat_nxt;

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cand      <= '0;
            sol_count <= '0;
            first_sol <= '0;
            found     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stop_lat  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            sol_count <= sol_count_nxt;
            first_sol <= first_sol_nxt;
            found     <= found_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            stop_lat  <= stop_lat_nxt;
        end
    end

    // Next-state, enumeration and result accumulation
    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        sol_count_nxt = sol_count;
        first_sol_nxt = first_sol;
        found_nxt     = found;
        stop_lat_nxt  = stop_lat;

        case (state)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cand_nxt  = '0;
                end else if (start) begin
                    state_nxt     = S_RUN;
                    cand_nxt      = '0;
                    sol_count_nxt = '0;
                    first_sol_nxt = '0;
                    found_nxt     = 1'b0;
                    stop_lat_nxt  = stop_first;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Partial results are kept; the vector in flight is dropped.
                    state_nxt = S_IDLE;
                    cand_nxt  = '0;
                end else begin
                    if (chk_valid) begin
                        sol_count_nxt = sol_count + CNT_W'(1);
                        if (!found) begin
                            first_sol_nxt = cand;
                            found_nxt     = 1'b1;
                        end
                    end
                    // cand freezes on the winning / last vector instead of wrapping.
                    if ((chk_valid && stop_lat) || (cand == CAND_LAST)) begin
                        state_nxt = S_DONE;
                    end else begin
                        cand_nxt = cand + N_ITEMS'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cand_nxt  = '0;
            end
        endcase

        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// tb_knap_search_ctrl: self-checking bench. A 4-item instance runs a table of
// directed searches, randomized searches against a reference model, and the
// abort/reset sequences; a 25-item instance runs one stop-at-first search.
module tb_knap_search_ctrl;

    logic clk;
    logic rst_n;

    // 4-item instance
    logic        start4, abort4, sf4, chk4;
    logic [3:0]  cand4, first4;
    logic [4:0]  cnt4;
    logic        busy4, done4, found4;
    logic [15:0] mask4;

    // 25-item instance
    logic        start25, abort25, sf25, chk25;
    logic [24:0] cand25, first25;
    logic [25:0] cnt25;
    logic        busy25, done25, found25;

    int tests;
    int fails;

    knap_search_ctrl #(.N_ITEMS(4), .CNT_W(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .stop_first(sf4), .cand(cand4), .chk_valid(chk4), .busy(busy4),
        .done(done4), .found(found4), .first_sol(first4), .sol_count(cnt4)
    );

    knap_search_ctrl #(.N_ITEMS(25), .CNT_W(26)) dut25 (
        .clk(clk), .rst_n(rst_n), .start(start25), .abort(abort25),
        .stop_first(sf25), .cand(cand25), .chk_valid(chk25), .busy(busy25),
        .done(done25), .found(found25), .first_sol(first25), .sol_count(cnt25)
    );

    // Checker models: valid set as a bitmask, and a single injected hit.
    assign chk4  = mask4[cand4];
    assign chk25 = (cand25 == 25'h0000123);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mask;
        logic        sf;
        int          exp_cycles;
        int          exp_count;
        int          exp_first;
        int          exp_found;
        int          exp_cand;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: scan the valid set in enumeration order.
    task automatic model(input logic [15:0] m, input logic sf, output int cyc,
                         output int cnt, output int first, output int fnd, output int cnd);
        cnt = 0; first = 0; fnd = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                cnt++;
                if (fnd == 0) begin
                    first = i;
                    fnd   = 1;
                end
            end
        end
        if (sf && fnd != 0) begin
            cyc = first + 1; cnt = 1; cnd = first;
        end else begin
            cyc = 16; cnd = 15;
        end
    endtask

    // Start a search, optionally disturbing stop_first and start mid-run,
    // and count the cycles busy stays high.
    task automatic run4(input logic [15:0] m, input logic sf, input bit poke, output int cyc);
        @(negedge clk);
        mask4 = m; sf4 = sf; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        if (poke) sf4 = ~sf;
        cyc = 0;
        while (busy4 && cyc < 100) begin
            cyc++;
            start4 = poke && (cyc == 5);
            @(negedge clk);
        end
        start4 = 1'b0;
    endtask

    task automatic check_result4(input string tag, input int cyc, input int e_cyc, input int e_cnt,
                                 input int e_first, input int e_fnd, input int e_cand);
        check({tag, " cycles"}, 32'(cyc), 32'(e_cyc));
        check({tag, " done"}, 32'(done4), 32'd1);
        check({tag, " busy"}, 32'(busy4), 32'd0);
        check({tag, " found"}, 32'(found4), 32'(e_fnd));
        check({tag, " first_sol"}, 32'(first4), 32'(e_first));
        check({tag, " sol_count"}, 32'(cnt4), 32'(e_cnt));
        check({tag, " cand"}, 32'(cand4), 32'(e_cand));
        repeat (2) @(negedge clk);
        check({tag, " done held"}, 32'(done4), 32'd1);
        check({tag, " cand frozen"}, 32'(cand4), 32'(e_cand));
    endtask

    initial begin
        int cyc, e_cyc, e_cnt, e_first, e_fnd, e_cand;
        logic [15:0] m;
        logic sf;

        tests = 0; fails = 0;
        rst_n = 1'b0;
        start4 = 0; abort4 = 0; sf4 = 0; mask4 = '0;
        start25 = 0; abort25 = 0; sf25 = 0;

        tbl[0] = '{16'h1020, 1'b0, 16, 2, 5, 1, 15};
        tbl[1] = '{16'h1020, 1'b1, 6, 1, 5, 1, 5};
        tbl[2] = '{16'h0000, 1'b0, 16, 0, 0, 0, 15};
        tbl[3] = '{16'hFFFF, 1'b0, 16, 16, 0, 1, 15};
        tbl[4] = '{16'hFFFF, 1'b1, 1, 1, 0, 1, 0};
        tbl[5] = '{16'h8000, 1'b1, 16, 1, 15, 1, 15};

        #3;
        check("reset cand", 32'(cand4), 32'd0);
        check("reset busy", 32'(busy4), 32'd0);
        check("reset done", 32'(done4), 32'd0);
        check("reset found", 32'(found4), 32'd0);
        check("reset first_sol", 32'(first4), 32'd0);
        check("reset sol_count", 32'(cnt4), 32'd0);
        check("reset25 cand", 32'(cand25), 32'd0);
        check("reset25 sol_count", 32'(cnt25), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run4(tbl[i].mask, tbl[i].sf, 1'b0, cyc);
            check_result4($sformatf("tbl%0d", i), cyc, tbl[i].exp_cycles, tbl[i].exp_count,
                          tbl[i].exp_first, tbl[i].exp_found, tbl[i].exp_cand);
        end

        // Randomized searches against the reference model
        for (int i = 0; i < 20; i++) begin
            m  = (i % 2 == 0) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
            sf = 1'($urandom);
            model(m, sf, e_cyc, e_cnt, e_first, e_fnd, e_cand);
            run4(m, sf, (i % 3 == 0), cyc);
            check_result4($sformatf("rnd%0d", i), cyc, e_cyc, e_cnt, e_first, e_fnd, e_cand);
        end

        // Abort in the third RUN cycle keeps partial results
        @(negedge clk);
        mask4 = 16'h0002; sf4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        check("abort busy", 32'(busy4), 32'd0);
        check("abort done", 32'(done4), 32'd0);
        check("abort cand", 32'(cand4), 32'd0);
        check("abort sol_count", 32'(cnt4), 32'd1);
        check("abort first_sol", 32'(first4), 32'd1);
        check("abort found", 32'(found4), 32'd1);
        // start together with abort is ignored
        start4 = 1'b1; abort4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; abort4 = 1'b0;
        check("start+abort busy", 32'(busy4), 32'd0);
        check("start+abort done", 32'(done4), 32'd0);
        check("start+abort sol_count", 32'(cnt4), 32'd1);
        run4(16'h1020, 1'b0, 1'b0, cyc);
        check_result4("after abort", cyc, 16, 2, 5, 1, 15);

        // Asynchronous reset in the middle of a search
        @(negedge clk);
        mask4 = 16'hFFFF; sf4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst cand", 32'(cand4), 32'd0);
        check("midrst busy", 32'(busy4), 32'd0);
        check("midrst done", 32'(done4), 32'd0);
        check("midrst found", 32'(found4), 32'd0);
        check("midrst first_sol", 32'(first4), 32'd0);
        check("midrst sol_count", 32'(cnt4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run4(16'h0410, 1'b0, 1'b0, cyc);
        check_result4("after rst", cyc, 16, 2, 4, 1, 15);

        // 25-item instance, stop at the single injected hit
        @(negedge clk);
        sf25 = 1'b1; start25 = 1'b1;
        @(negedge clk);
        start25 = 1'b0; sf25 = 1'b0;
        cyc = 0;
        while (busy25 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        check("n25 cycles", 32'(cyc), 32'h124);
        check("n25 done", 32'(done25), 32'd1);
        check("n25 found", 32'(found25), 32'd1);
        check("n25 first_sol", 32'(first25), 32'h123);
        check("n25 sol_count", 32'(cnt25), 32'd1);
        check("n25 cand", 32'(cand25), 32'h123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
